// File: rtl/block_token_emitter_pkg.sv
// Shared definitions for the begin/end block token emitter: token codes,
// ASCII constants and per-token character counts.
package block_token_emitter_pkg;

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned CHAR_W = 8;

   typedef enum logic [1:0] {
      TOK_SPACE = 2'b00,
      TOK_BEGIN = 2'b01,
      TOK_END   = 2'b10,
      TOK_PAD   = 2'b11
   } token_e;

   localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
   localparam logic [CHAR_W-1:0] ASCII_B     = 8'h62;
   localparam logic [CHAR_W-1:0] ASCII_D     = 8'h64;
   localparam logic [CHAR_W-1:0] ASCII_E     = 8'h65;
   localparam logic [CHAR_W-1:0] ASCII_G     = 8'h67;
   localparam logic [CHAR_W-1:0] ASCII_I     = 8'h69;
   localparam logic [CHAR_W-1:0] ASCII_N     = 8'h6E;
   localparam logic [CHAR_W-1:0] CASE_OFFSET = 8'h20;

   localparam logic [IDX_W-1:0] LEN_SPACE = 3'd1;
   localparam logic [IDX_W-1:0] LEN_BEGIN = 3'd6;
   localparam logic [IDX_W-1:0] LEN_END   = 3'd4;
   localparam logic [IDX_W-1:0] LEN_PAD   = 3'd2;

   // Index of the final character (always the trailing space) of a token
   function automatic logic [IDX_W-1:0] tok_last(input token_e tok);
      logic [IDX_W-1:0] len;
      case (tok)
         TOK_BEGIN: len = LEN_BEGIN;
         TOK_END:   len = LEN_END;
         TOK_PAD:   len = LEN_PAD;
         default:   len = LEN_SPACE;
      endcase
      return len - IDX_W'(1);
   endfunction

endpackage

// File: rtl/block_token_rom.sv
// Combinational character table: (token, index) -> ASCII character plus a
// flag marking the token's final character.
module block_token_rom
   import block_token_emitter_pkg::*;
#(
   parameter bit               UPPER     = 1'b0,
   parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h78
) (
   input  token_e             token,
   input  logic [IDX_W-1:0]   idx,
   output logic [CHAR_W-1:0]  char_c,
   output logic               last_c
);

   logic [CHAR_W-1:0] base;
   logic              is_letter;

   always_comb begin
      base      = ASCII_SPACE;
      is_letter = 1'b0;
      case (token)
         TOK_BEGIN: begin
            is_letter = 1'b1;
            case (idx)
               3'd0:    base = ASCII_B;
               3'd1:    base = ASCII_E;
               3'd2:    base = ASCII_G;
               3'd3:    base = ASCII_I;
               3'd4:    base = ASCII_N;
               default: is_letter = 1'b0;
            endcase
         end
         TOK_END: begin
            is_letter = 1'b1;
            case (idx)
               3'd0:    base = ASCII_E;
               3'd1:    base = ASCII_N;
               3'd2:    base = ASCII_D;
               default: is_letter = 1'b0;
            endcase
         end
         // Fill character is passed through untouched, never case-folded
         TOK_PAD: begin
            if (idx == 3'd0) base = FILL_CHAR;
         end
         default: base = ASCII_SPACE;
      endcase

      char_c = (UPPER && is_letter) ? base - CASE_OFFSET : base;
      last_c = (idx == tok_last(token));
   end

endmodule

// File: rtl/block_token_emitter.sv
// Turns BEGIN/END/PAD/SPACE commands into a space-separated ASCII character
// stream and tracks block nesting depth and balance.
module block_token_emitter
   import block_token_emitter_pkg::*;
#(
   parameter int unsigned       DEPTH_W   = 8,
   parameter bit                UPPER     = 1'b0,
   parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h78
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic [1:0]         cmd,
   output logic               cmd_ready,
   output logic [CHAR_W-1:0]  out_char,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DEPTH_W-1:0] depth,
   output logic               err,
   output logic               balanced
);

   typedef enum logic {IDLE, EMIT} state_e;

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

   state_e             state_q, state_d;
   token_e             tok_q, tok_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               last_q, last_d;
   logic [DEPTH_W-1:0] depth_d;
   logic               err_d, cmd_ready_d, out_valid_d;
   logic [CHAR_W-1:0]  out_char_d;
   logic               load;
   logic [CHAR_W-1:0]  rom_char;
   logic               rom_last;

   // Table is addressed by the next token/index so the character lands in a register
   block_token_rom #(
      .UPPER     (UPPER),
      .FILL_CHAR (FILL_CHAR)
   ) u_rom (
      .token  (tok_d),
      .idx    (idx_d),
      .char_c (rom_char),
      .last_c (rom_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         tok_q     <= TOK_SPACE;
         idx_q     <= '0;
         last_q    <= 1'b0;
         depth     <= '0;
         err       <= 1'b0;
         cmd_ready <= 1'b1;
         out_valid <= 1'b0;
         out_char  <= '0;
      end else begin
         state_q   <= state_d;
         tok_q     <= tok_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         depth     <= depth_d;
         err       <= err_d;
         cmd_ready <= cmd_ready_d;
         out_valid <= out_valid_d;
         out_char  <= out_char_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tok_d       = tok_q;
      idx_d       = idx_q;
      depth_d     = depth;
      err_d       = err;
      cmd_ready_d = cmd_ready;
      out_valid_d = out_valid;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               tok_d       = token_e'(cmd);
               idx_d       = '0;
               state_d     = EMIT;
               cmd_ready_d = 1'b0;
               out_valid_d = 1'b1;
               load        = 1'b1;
               // Error tokens still emit their characters; depth saturates
               if (tok_d == TOK_BEGIN) begin
                  if (depth != DEPTH_MAX) depth_d = depth + DEPTH_W'(1);
                  else                    err_d   = 1'b1;
               end else if (tok_d == TOK_END) begin
                  if (depth != '0) depth_d = depth - DEPTH_W'(1);
                  else             err_d   = 1'b1;
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d     = IDLE;
                  cmd_ready_d = 1'b1;
                  out_valid_d = 1'b0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  load  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      out_char_d = load ? rom_char : out_char;
      last_d     = load ? rom_last : last_q;
   end

   assign balanced = (depth == '0) && !err;

endmodule
